// File: rtl/cur_block_fetch.sv
// cur_block_fetch: prefetches 8x8 current-frame blocks (raster order) into a
// 2-bank x 16-word store and streams one block per need_cur burst.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   frame_start       restart fetching at block (0,0)
//   mem_rd/mem_addr   one word read per cycle, data back MEM_LAT cycles later
//   mem_rdata         read data, pixel x+0 in [7:0]
//   need_cur/cur_in   consumer handshake and combinational stream word
//   cur_ready         a complete block waits in the fill bank
//   blk_x/blk_y       coordinates of the block last streamed
//   last_blk          the block last streamed ends the frame
//   underrun          sticky: a stream began with no block pending
module cur_block_fetch #(
  parameter int FRAME_W = 64,
  parameter int FRAME_H = 64,
  parameter int MEM_LAT = 2,
  parameter int AW      = 16,
  localparam int NBX = FRAME_W / 8,
  localparam int NBY = FRAME_H / 8,
  localparam int BXW = (NBX > 1) ? $clog2(NBX) : 1,
  localparam int BYW = (NBY > 1) ? $clog2(NBY) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_start,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_rdata,
  input  logic          need_cur,
  output logic [31:0]   cur_in,
  output logic          cur_ready,
  output logic [BXW-1:0] blk_x,
  output logic [BYW-1:0] blk_y,
  output logic          last_blk,
  output logic          underrun
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_FULL
  } state_e;

  state_e state_q, state_d;

  logic           rd_bank_q, rd_bank_d;
  logic           pending_q, pending_d;
  logic [3:0]     ptr_q, ptr_d;
  logic           ncd_q, ncd_d;
  logic [3:0]     k_q, k_d;
  logic [BXW-1:0] bx_q, bx_d;
  logic [BYW-1:0] by_q, by_d;
  logic [BXW-1:0] blk_x_q, blk_x_d;
  logic [BYW-1:0] blk_y_q, blk_y_d;
  logic           last_q, last_d;
  logic           und_q, und_d;

  // In-flight read tags: valid bit and word index per latency stage.
  logic [MEM_LAT-1:0] sv_q, sv_d;
  logic [3:0]         sk_q [MEM_LAT];
  logic [3:0]         sk_d [MEM_LAT];

  logic [31:0] store_q [2][16];

  logic         ss;
  logic [3:0]   idx;
  logic         flip;
  logic         bank_eff;
  logic         ret_v;
  logic [3:0]   ret_k;
  logic         at_last;
  logic [BYW+2:0] row;
  logic [BXW:0]   col;

  assign ss       = need_cur & ~ncd_q;
  assign idx      = ss ? 4'd0 : ptr_q;
  assign flip     = ss & pending_q;
  assign bank_eff = flip ? ~rd_bank_q : rd_bank_q;
  assign ret_v    = sv_q[MEM_LAT-1] & ~frame_start;
  assign ret_k    = sk_q[MEM_LAT-1];
  assign at_last  = (bx_q == BXW'(NBX - 1)) &&
                    (by_q == BYW'(NBY - 1));

  assign row      = {by_q, k_q[3:1]};
  assign col      = {bx_q, k_q[0]};
  assign mem_rd   = (state_q == S_FETCH);
  assign mem_addr = AW'(row) * AW'(FRAME_W / 4) + AW'(col);

  assign cur_in    = store_q[bank_eff][idx];
  assign cur_ready = pending_q;
  assign blk_x     = blk_x_q;
  assign blk_y     = blk_y_q;
  assign last_blk  = last_q;
  assign underrun  = und_q;

  always_comb begin
    state_d   = state_q;
    rd_bank_d = rd_bank_q;
    pending_d = pending_q;
    k_d       = k_q;
    bx_d      = bx_q;
    by_d      = by_q;
    blk_x_d   = blk_x_q;
    blk_y_d   = blk_y_q;
    last_d    = last_q;
    und_d     = und_q;
    ncd_d     = need_cur;

    // Saturate at word 15: the consumer keeps rewriting it until its swap.
    if (need_cur) begin
      ptr_d = (idx == 4'd15) ? 4'd15 : idx + 4'd1;
    end else begin
      ptr_d = ptr_q;
    end

    sv_d[0] = mem_rd;
    sk_d[0] = k_q;
    for (int i = 1; i < MEM_LAT; i++) begin
      sv_d[i] = sv_q[i-1];
      sk_d[i] = sk_q[i-1];
    end

    if (ss) begin
      if (pending_q) begin
        rd_bank_d = ~rd_bank_q;
        pending_d = 1'b0;
        blk_x_d   = bx_q;
        blk_y_d   = by_q;
        last_d    = at_last;
      end else begin
        und_d = 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
      end
      S_FETCH: begin
        k_d = k_q + 4'd1;
        if (k_q == 4'd15) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // A return landing with ss still counts as pending for the next ss.
        if (ret_v && ret_k == 4'd15) begin
          pending_d = 1'b1;
          state_d   = S_FULL;
        end
      end
      S_FULL: begin
        if (flip) begin
          if (at_last) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_FETCH;
            k_d     = 4'd0;
            if (bx_q == BXW'(NBX - 1)) begin
              bx_d = '0;
              by_d = by_q + BYW'(1);
            end else begin
              bx_d = bx_q + BXW'(1);
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (frame_start) begin
      state_d   = S_FETCH;
      pending_d = 1'b0;
      k_d       = 4'd0;
      bx_d      = '0;
      by_d      = '0;
      sv_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rd_bank_q <= 1'b0;
      pending_q <= 1'b0;
      ptr_q     <= 4'd0;
      ncd_q     <= 1'b0;
      k_q       <= 4'd0;
      bx_q      <= '0;
      by_q      <= '0;
      blk_x_q   <= '0;
      blk_y_q   <= '0;
      last_q    <= 1'b0;
      und_q     <= 1'b0;
      sv_q      <= '0;
      for (int i = 0; i < MEM_LAT; i++) begin
        sk_q[i] <= 4'd0;
      end
    end else begin
      state_q   <= state_d;
      rd_bank_q <= rd_bank_d;
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      ncd_q     <= ncd_d;
      k_q       <= k_d;
      bx_q      <= bx_d;
      by_q      <= by_d;
      blk_x_q   <= blk_x_d;
      blk_y_q   <= blk_y_d;
      last_q    <= last_d;
      und_q     <= und_d;
      sv_q      <= sv_d;
      for (int i = 0; i < MEM_LAT; i++) begin
        sk_q[i] <= sk_d[i];
      end
    end
  end

  // Block store is not reset; returns always land in the fill bank.
  always_ff @(posedge clk) begin
    if (ret_v && !rst) begin
      store_q[~rd_bank_q][ret_k] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_cur_block_fetch.sv
// tb_cur_block_fetch: directed plus randomized streaming of cur_block_fetch
// against a block-level reference model.
module tb_cur_block_fetch;
  localparam int FW  = 64;
  localparam int FH  = 64;
  localparam int L   = 2;
  localparam int AW  = 16;
  localparam int NBX = FW / 8;
  localparam int NBY = FH / 8;
  localparam int NB  = NBX * NBY;
  localparam int XW  = $clog2(NBX);
  localparam int YW  = $clog2(NBY);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_start = 1'b0;
  logic          need_cur = 1'b0;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata;
  logic [31:0]   cur_in;
  logic          cur_ready;
  logic [XW-1:0] blk_x;
  logic [YW-1:0] blk_y;
  logic          last_blk;
  logic          underrun;

  always #5 clk = ~clk;

  cur_block_fetch #(
    .FRAME_W(FW),
    .FRAME_H(FH),
    .MEM_LAT(L),
    .AW(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .frame_start(frame_start),
    .mem_rd(mem_rd),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .need_cur(need_cur),
    .cur_in(cur_in),
    .cur_ready(cur_ready),
    .blk_x(blk_x),
    .blk_y(blk_y),
    .last_blk(last_blk),
    .underrun(underrun)
  );

  function automatic logic [31:0] dat(input logic [AW-1:0] a);
    return {a ^ 16'hBEEF, a};
  endfunction

  function automatic logic [AW-1:0] waddr(input int b, input int k);
    int bx = b % NBX;
    int by = b / NBX;
    int r  = k / 2;
    int h  = k % 2;
    return AW'(((by * 8 + r) * FW + bx * 8 + h * 4) / 4);
  endfunction

  // Fixed-latency memory; garbage on cycles with no read.
  logic [31:0] rpipe [L];
  always @(posedge clk) begin
    rpipe[0] <= mem_rd ? dat(mem_addr) : $urandom;
    for (int i = 1; i < L; i++) begin
      rpipe[i] <= rpipe[i-1];
    end
  end
  assign mem_rdata = rpipe[L-1];

  int ncmp = 0;
  int nerr = 0;
  int cyc = 0;

  int m_pend = 0;
  int m_rdb = 0;
  int m_ptr = 0;
  int m_ncd = 0;
  int m_und = 0;
  int f_on = 0;
  int f_blk = 0;
  int f_start = 0;
  int e_bx = 0;
  int e_by = 0;
  int e_last = 0;
  int bank_blk [2] = '{-1, -1};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input bit c);
    int ss;
    int idx;
    int bank;
    int n;
    int done;
    int e_rd;
    @(negedge clk);
    ss   = (need_cur && m_ncd == 0) ? 1 : 0;
    idx  = ss ? 0 : m_ptr;
    bank = (ss && m_pend) ? 1 - m_rdb : m_rdb;
    e_rd = (f_on && cyc - f_start < 16) ? 1 : 0;
    if (c) begin
      chk("mem_rd", 32'(mem_rd), e_rd);
      if (e_rd)
        chk("mem_addr", 32'(mem_addr), 32'(waddr(f_blk, cyc - f_start)));
      chk("cur_ready", 32'(cur_ready), m_pend);
      chk("underrun", 32'(underrun), m_und);
      chk("blk_x", 32'(blk_x), e_bx);
      chk("blk_y", 32'(blk_y), e_by);
      chk("last_blk", 32'(last_blk), e_last);
      if (bank_blk[bank] >= 0)
        chk("cur_in", cur_in, dat(waddr(bank_blk[bank], idx)));
    end
    @(posedge clk);
    n = cyc + 1;
    if (rst) begin
      m_pend = 0; m_rdb = 0; m_ptr = 0; m_ncd = 0; m_und = 0;
      f_on = 0; f_blk = 0; e_bx = 0; e_by = 0; e_last = 0;
    end else begin
      done = (f_on && n == f_start + 16 + L) ? 1 : 0;
      if (need_cur) m_ptr = (idx + 1 > 15) ? 15 : idx + 1;
      m_ncd = need_cur ? 1 : 0;
      if (ss && m_pend) begin
        m_rdb  = 1 - m_rdb;
        m_pend = 0;
        e_bx   = f_blk % NBX;
        e_by   = f_blk / NBX;
        e_last = (f_blk == NB - 1) ? 1 : 0;
        if (f_blk < NB - 1) begin
          f_blk++;
          f_on = 1;
          f_start = n;
          bank_blk[1 - m_rdb] = -1;
        end
      end else if (ss) begin
        m_und = 1;
      end
      if (done && !frame_start) begin
        f_on = 0;
        m_pend = 1;
        bank_blk[1 - m_rdb] = f_blk;
      end
      if (frame_start) begin
        m_pend = 0;
        f_blk = 0;
        f_on = 1;
        f_start = n;
        bank_blk[1 - m_rdb] = -1;
      end
    end
    cyc = n;
    #1;
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 200 && cur_ready !== 1'b1; i++) tick(1);
    chk(tag, 32'(cur_ready), 1);
  endtask

  initial begin
    int target;
    int gap;
    int len;

    // Reset and idle state.
    rst = 1'b1;
    tick(0);
    tick(0);
    rst = 1'b0;
    tick(1);
    chk("rst_mem_rd", 32'(mem_rd), 0);
    chk("rst_underrun", 32'(underrun), 0);
    tick(1);

    // First block fetch; stream starts exactly as the last return lands.
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    target = f_start + 15 + L;
    for (int i = 0; i < 100 && cyc < target; i++) tick(1);
    chk("sim_align", cyc, target);
    need_cur = 1'b1;
    repeat (16) tick(1);
    need_cur = 1'b0;
    chk("sim_underrun", 32'(underrun), 1);
    chk("sim_pending", 32'(cur_ready), 1);
    repeat (3) tick(1);

    // Stream block 0 and hold word 15 afterwards.
    need_cur = 1'b1;
    repeat (16) tick(1);
    need_cur = 1'b0;
    repeat (4) tick(1);
    chk("hold_w15", cur_in, dat(16'd113));
    chk("blk0_x", 32'(blk_x), 0);

    // Randomized consumer timing across the rest of the frame.
    for (int it = 0; it < 600 && !(e_last == 1 && f_on == 0 && m_pend == 0);
         it++) begin
      gap = $urandom_range(0, 20);
      repeat (gap) tick(1);
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 24) : 16;
      need_cur = 1'b1;
      repeat (len) tick(1);
      need_cur = 1'b0;
    end
    repeat (4) tick(1);
    chk("end_last_blk", 32'(last_blk), 1);
    chk("end_blk_x", 32'(blk_x), NBX - 1);
    chk("end_blk_y", 32'(blk_y), NBY - 1);
    chk("end_idle_rd", 32'(mem_rd), 0);

    // Stream with nothing pending after the frame is done.
    need_cur = 1'b1;
    repeat (16) tick(1);
    need_cur = 1'b0;
    tick(1);
    chk("late_underrun", 32'(underrun), 1);
    chk("late_blk_x", 32'(blk_x), NBX - 1);

    // Restart during drain.
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    target = f_start + 16;
    for (int i = 0; i < 100 && cyc < target; i++) tick(1);
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    chk("restart_addr", 32'(mem_addr), 0);
    wait_ready("restart_ready");
    tick(1);
    need_cur = 1'b1;
    repeat (16) tick(1);
    need_cur = 1'b0;
    repeat (3) tick(1);
    chk("restart_blk_x", 32'(blk_x), 0);

    // Reset in the middle of a stream.
    need_cur = 1'b1;
    repeat (5) tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rst2_mem_rd", 32'(mem_rd), 0);
    chk("rst2_ready", 32'(cur_ready), 0);
    chk("rst2_underrun", 32'(underrun), 0);
    repeat (3) tick(1);
    need_cur = 1'b0;
    repeat (3) tick(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
